// File: rtl/cu_seq_if.sv
// Program-memory and datapath-control bundle between cu_sequencer (master)
// and the ROM / computational unit (slave).
interface cu_seq_if #(
    parameter int PC_W = 8
);
    logic [PC_W-1:0] pm_addr;
    logic [7:0]      pm_data;
    logic            r_eq_0;
    logic [3:0]      nibble_ir;
    logic [3:0]      source_sel;
    logic [9:0]      reg_en;
    logic            i_sel;
    logic            x_sel;
    logic            y_sel;

    modport master (
        output pm_addr, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel,
        input  pm_data, r_eq_0
    );

    modport slave (
        input  pm_addr, nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel,
        output pm_data, r_eq_0
    );
endinterface

// File: rtl/cu_sequencer.sv
// Program sequencer and instruction decoder for the 4-bit computational unit.
// Optional single-step port pair enabled by defining CU_SEQ_STEP_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RESET | entered on reset, outputs idle
// ST_FILL  | refill bubble: ir <= rom, pc <= pc+1
// ST_EXEC  | decode live (when run or single-step), ir/pc advance or jump
// ST_HOLD  | bubble with pc and ir frozen
module cu_sequencer #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            sync_reset_n,
    input  logic            run,
`ifdef CU_SEQ_STEP_EN
    input  logic            step_req,
    output logic            step_ack,
`endif
    cu_seq_if.master        bus,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic            executing
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FILL  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [7:0]      ir_nxt;
    logic            live;
    logic            jump_taken;
    logic            step_mode;
    logic            step_mode_nxt;
    logic            step_go;

    logic [2:0]      dest;
    logic [2:0]      src;
    logic            wr;
    logic            src_dm;

`ifdef CU_SEQ_STEP_EN
    assign step_go = (state == ST_HOLD) && !run && step_req;

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            step_mode <= 1'b0;
            step_ack  <= 1'b0;
        end else begin
            step_mode <= step_mode_nxt;
            step_ack  <= (state == ST_EXEC) && step_mode;
        end
    end
`else
    assign step_go   = 1'b0;
    assign step_mode = 1'b0;
`endif

    // A stepped instruction executes even though run is low.
    assign live      = (state == ST_EXEC) && (run || step_mode);
    assign executing = live;

    assign bus.pm_addr   = pc;
    assign bus.nibble_ir = ir[3:0];

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state <= ST_RESET;
            pc    <= '0;
            ir    <= 8'h00;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ir_nxt        = ir;
        step_mode_nxt = 1'b0;
        unique case (state)
            ST_RESET: state_nxt = ST_FILL;
            ST_FILL: begin
                ir_nxt    = bus.pm_data;
                pc_nxt    = pc + 1'b1;
                state_nxt = run ? ST_EXEC : ST_HOLD;
            end
            ST_EXEC: begin
                if (live) begin
                    ir_nxt = bus.pm_data;
                    if (jump_taken) begin
                        pc_nxt    = {pc[PC_W-1:4], ir[3:0]};
                        state_nxt = ST_FILL;
                    end else begin
                        pc_nxt    = pc + 1'b1;
                        state_nxt = step_mode ? ST_HOLD : ST_EXEC;
                    end
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (run) begin
                    state_nxt = ST_EXEC;
                end else if (step_go) begin
                    state_nxt     = ST_EXEC;
                    step_mode_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_RESET;
        endcase
    end

    always_comb begin
        bus.source_sel = 4'd0;
        bus.reg_en     = 10'd0;
        bus.i_sel      = 1'b0;
        bus.x_sel      = 1'b0;
        bus.y_sel      = 1'b0;
        jump_taken     = 1'b0;
        dest           = 3'd0;
        src            = 3'd0;
        wr             = 1'b0;
        src_dm         = 1'b0;
        if (live) begin
            casez (ir)
                8'b0???_????: begin
                    dest           = ir[6:4];
                    wr             = 1'b1;
                    bus.source_sel = 4'd8;
                end
                8'b10??_????: begin
                    dest           = ir[5:3];
                    src            = ir[2:0];
                    wr             = 1'b1;
                    src_dm         = (ir[2:0] == 3'd7);
                    bus.source_sel = (ir[5:3] == ir[2:0]) ? 4'd9 : {1'b0, ir[2:0]};
                end
                8'b110?_????: begin
                    bus.x_sel     = ir[4];
                    bus.y_sel     = ir[3];
                    bus.reg_en[4] = 1'b1;
                end
                8'b1110_????: jump_taken = 1'b1;
                default:      jump_taken = !bus.r_eq_0;
            endcase
            if (wr) begin
                unique case (dest)
                    3'd0: bus.reg_en[0] = 1'b1;
                    3'd1: bus.reg_en[1] = 1'b1;
                    3'd2: bus.reg_en[2] = 1'b1;
                    3'd3: bus.reg_en[3] = 1'b1;
                    3'd4: bus.reg_en[8] = 1'b1;
                    3'd5: bus.reg_en[5] = 1'b1;
                    3'd6: bus.reg_en[6] = 1'b1;
                    3'd7: bus.reg_en[7] = 1'b1;
                    default: ;
                endcase
                // dm accesses post-increment i, except when i is being loaded.
                if ((dest == 3'd7 || src_dm) && dest != 3'd6) begin
                    bus.reg_en[6] = 1'b1;
                    bus.i_sel     = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_cu_sequencer;

    logic       clk = 1'b0;
    logic       sync_reset_n = 1'b0;
    logic       run = 1'b1;
    logic       step_req = 1'b0;
    logic       step_ack;
    logic       r_eq_0_drv = 1'b1;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       executing;
    logic [7:0] rom [256];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        int         cyc;
        int         tag;
        logic [7:0] pc;
        logic [7:0] ir;
        logic [3:0] src;
        logic [9:0] en;
        logic       isel;
        logic       xs;
        logic       ys;
        logic       exe;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   tag_n = 0;

    cu_seq_if #(.PC_W(8)) bus ();

    assign bus.pm_data = rom[bus.pm_addr];
    assign bus.r_eq_0  = r_eq_0_drv;

    cu_sequencer #(.PC_W(8)) dut (
        .clk          (clk),
        .sync_reset_n (sync_reset_n),
        .run          (run),
`ifdef CU_SEQ_STEP_EN
        .step_req     (step_req),
        .step_ack     (step_ack),
`endif
        .bus          (bus.master),
        .pc           (pc),
        .ir           (ir),
        .executing    (executing)
    );

`ifndef CU_SEQ_STEP_EN
    assign step_ack = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL step%0d %s: got %0h expected %0h (cycle %0d)", tag, fld, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL step%0d stale: got no sample expected cycle %0d", sb[0].tag, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, "pc",         32'(pc),             32'(e.pc));
            chk(e.tag, "ir",         32'(ir),             32'(e.ir));
            chk(e.tag, "nibble_ir",  32'(bus.nibble_ir),  32'(e.ir[3:0]));
            chk(e.tag, "pm_addr",    32'(bus.pm_addr),    32'(e.pc));
            chk(e.tag, "source_sel", 32'(bus.source_sel), 32'(e.src));
            chk(e.tag, "reg_en",     32'(bus.reg_en),     32'(e.en));
            chk(e.tag, "i_sel",      32'(bus.i_sel),      32'(e.isel));
            chk(e.tag, "x_sel",      32'(bus.x_sel),      32'(e.xs));
            chk(e.tag, "y_sel",      32'(bus.y_sel),      32'(e.ys));
            chk(e.tag, "executing",  32'(executing),      32'(e.exe));
`ifdef CU_SEQ_STEP_EN
            chk(e.tag, "step_ack",   32'(step_ack),       32'(e.ack));
`endif
        end
    end

    task automatic drive(input logic rn, input logic rv, input logic sr, input logic rz);
        @(posedge clk);
        #1;
        sync_reset_n = rn;
        run          = rv;
        step_req     = sr;
        r_eq_0_drv   = rz;
    endtask

    task automatic expect_cyc(input logic [7:0] pcv, input logic [7:0] irv, input logic [3:0] src,
                              input logic [9:0] en, input logic isel, input logic xs, input logic ys,
                              input logic exe, input logic ack);
        exp_t e;
        tag_n++;
        e.cyc = cyc; e.tag = tag_n; e.pc = pcv; e.ir = irv; e.src = src; e.en = en;
        e.isel = isel; e.xs = xs; e.ys = ys; e.exe = exe; e.ack = ack;
        sb.push_back(e);
    endtask

    task automatic bubble(input logic [7:0] pcv, input logic [7:0] irv, input logic ack);
        expect_cyc(pcv, irv, 4'd0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, ack);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0]  = 8'h05;  // x0 <= 5
        rom[1]  = 8'hB7;  // i <= dm
        rom[2]  = 8'hB8;  // dm <= x0, i += m
        rom[3]  = 8'hE9;  // jump 9
        rom[4]  = 8'h0F;  // skipped by the jump
        rom[9]  = 8'hBF;  // dm <= i_pins, i += m
        rom[10] = 8'hD5;  // alu x=1 y=0 f=5
        rom[11] = 8'hF2;  // jnz 2 (not taken)
        rom[12] = 8'hF2;  // jnz 2 (taken)
        rom[13] = 8'h31;

        drive(0, 1, 0, 1); bubble(8'd0, 8'h00, 0);                                   // reset
        drive(1, 1, 0, 1); bubble(8'd0, 8'h00, 0);                                   // RESET
        drive(1, 1, 0, 1); bubble(8'd0, 8'h00, 0);                                   // FILL
        drive(1, 1, 0, 1); expect_cyc(8'd1, 8'h05, 4'd8, 10'h001, 0, 0, 0, 1, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd2, 8'hB7, 4'd7, 10'h040, 0, 0, 0, 1, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd3, 8'hB8, 4'd0, 10'h0C0, 1, 0, 0, 1, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd4, 8'hE9, 4'd0, 10'h000, 0, 0, 0, 1, 0);
        drive(1, 1, 0, 1); bubble(8'd9, 8'h0F, 0);                                   // jump bubble
        drive(1, 1, 0, 1); expect_cyc(8'd10, 8'hBF, 4'd9, 10'h0C0, 1, 0, 0, 1, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd11, 8'hD5, 4'd0, 10'h010, 0, 1, 0, 1, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd12, 8'hF2, 4'd0, 10'h000, 0, 0, 0, 1, 0); // jnz falls through
        drive(1, 1, 0, 0); expect_cyc(8'd13, 8'hF2, 4'd0, 10'h000, 0, 0, 0, 1, 0); // jnz taken
        drive(1, 1, 0, 1); bubble(8'd2, 8'h31, 0);
        drive(1, 0, 0, 1); bubble(8'd3, 8'hB8, 0);                                   // run low
        drive(1, 0, 0, 1); bubble(8'd3, 8'hB8, 0);
        drive(1, 0, 0, 1); bubble(8'd3, 8'hB8, 0);
        drive(1, 1, 0, 1); bubble(8'd3, 8'hB8, 0);                                   // run rises
        drive(1, 1, 0, 1); expect_cyc(8'd3, 8'hB8, 4'd0, 10'h0C0, 1, 0, 0, 1, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd4, 8'hE9, 4'd0, 10'h000, 0, 0, 0, 1, 0);
        drive(0, 1, 0, 1); bubble(8'd9, 8'h0F, 0);                                   // reset in FILL
        drive(1, 1, 0, 1); bubble(8'd0, 8'h00, 0);
        drive(1, 0, 0, 1); bubble(8'd0, 8'h00, 0);                                   // FILL, run drops
        drive(1, 0, 1, 1); bubble(8'd1, 8'h05, 0);                                   // HOLD
`ifdef CU_SEQ_STEP_EN
        drive(1, 0, 0, 1); expect_cyc(8'd1, 8'h05, 4'd8, 10'h001, 0, 0, 0, 1, 0); // stepped exec
        drive(1, 0, 0, 1); bubble(8'd2, 8'hB7, 1);
        drive(1, 1, 0, 1); bubble(8'd2, 8'hB7, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd2, 8'hB7, 4'd7, 10'h040, 0, 0, 0, 1, 0);
`else
        drive(1, 0, 0, 1); bubble(8'd1, 8'h05, 0);
        drive(1, 1, 0, 1); bubble(8'd1, 8'h05, 0);
        drive(1, 1, 0, 1); expect_cyc(8'd1, 8'h05, 4'd8, 10'h001, 0, 0, 0, 1, 0);
`endif
        @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
